// File: rtl/fifo_sample_reader_if.sv
// Sample stream between the FIFO drain engine and the FIR tap engine.
// valid/ready handshake, with last marking the final sample of each block.
interface fifo_sample_reader_if #(
    parameter int unsigned DATABITS = 16
) ();
    logic                valid;
    logic                ready;
    logic [DATABITS-1:0] data;
    logic                last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fifo_sample_reader.sv
// FIR-domain drain engine: pops the sample FIFO into a 2-entry skid buffer,
// streams samples out with block boundaries and counts starved cycles.
module fifo_sample_reader #(
    parameter int unsigned DATABITS   = 16,
    parameter int unsigned BLOCK_LEN  = 64,
    parameter int unsigned CNT_BITS   = 6,
    parameter int unsigned UFLOW_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATABITS-1:0]   fifo_rdata,
    output logic                  fifo_rd_en,
    fifo_sample_reader_if.master  m,
    output logic [CNT_BITS-1:0]   sample_idx,
    output logic [UFLOW_BITS-1:0] uflow_cnt
);
    localparam logic [CNT_BITS-1:0]   LAST_IDX  = CNT_BITS'(BLOCK_LEN - 1);
    localparam logic [UFLOW_BITS-1:0] UFLOW_MAX = '1;

    logic [1:0]          occ;
    logic                inflight;
    logic [DATABITS-1:0] head;
    logic [DATABITS-1:0] tail;

    logic       hs_raw_c;
    logic       hs_c;
    logic       cap_c;
    logic       starve_c;
    logic [2:0] load_c;
    logic [2:0] limit_c;

    // Stream view of the skid buffer head
    assign m.valid = (occ != 2'd0);
    assign m.data  = head;
    assign m.last  = m.valid && (sample_idx == LAST_IDX);

    // Pop only when the buffer still has room once in-flight data and this cycle's handshake settle
    always_comb begin
        hs_raw_c   = m.valid & m.ready;
        hs_c       = hs_raw_c & ~flush;
        cap_c      = inflight & ~flush;
        load_c     = {1'b0, occ} + {2'b00, inflight};
        limit_c    = 3'd2 + {2'b00, hs_raw_c};
        fifo_rd_en = rstn & enable & ~flush & ~fifo_empty & (load_c < limit_c);
        starve_c   = enable & m.ready & ~m.valid & ~inflight & ~flush;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ        <= 2'd0;
            inflight   <= 1'b0;
            head       <= '0;
            tail       <= '0;
            sample_idx <= '0;
            uflow_cnt  <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (starve_c && (uflow_cnt != UFLOW_MAX))
                uflow_cnt <= uflow_cnt + UFLOW_BITS'(1);

            if (flush) begin
                occ        <= 2'd0;
                sample_idx <= '0;
            end else begin
                if (hs_c)
                    sample_idx <= (sample_idx == LAST_IDX) ? '0 : sample_idx + CNT_BITS'(1);

                // Head advance and tail capture; simultaneous case keeps FIFO order
                case ({hs_c, cap_c})
                    2'b11: begin
                        if (occ == 2'd2) begin
                            head <= tail;
                            tail <= fifo_rdata;
                        end else begin
                            head <= fifo_rdata;
                        end
                    end
                    2'b10: begin
                        head <= tail;
                        occ  <= occ - 2'd1;
                    end
                    2'b01: begin
                        if (occ == 2'd0) head <= fifo_rdata;
                        else             tail <= fifo_rdata;
                        occ <= occ + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(cap_c && !hs_c && (occ == 2'd2)));

endmodule
